// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the i2c APB register bank: bus FSM states, register
// indices (PADDR[4:2]) and STATUS / interrupt bit positions.
package i2c_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RX_WAIT = 2'd3
    } apb_state_e;

    // Word index of each register; byte offset = index * 4
    typedef enum logic [2:0] {
        REG_PRESCALE = 3'd0,
        REG_CMD      = 3'd1,
        REG_SLV_ADDR = 3'd2,
        REG_TX_DATA  = 3'd3,
        REG_RX_DATA  = 3'd4,
        REG_STATUS   = 3'd5,
        REG_INT_STAT = 3'd6,
        REG_INT_EN   = 3'd7
    } reg_idx_e;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 3;

    localparam int INT_CORE   = 0;
    localparam int INT_TX_OVF = 1;
    localparam int INT_RX_UNF = 2;
    localparam int INT_W      = 3;

endpackage

// File: rtl/i2c_irq_ctrl.sv
// Interrupt controller: rising-edge detect on the core interrupt, sticky W1C
// flags (a set beats a simultaneous clear), enable mask and registered irq_o.
module i2c_irq_ctrl
    import i2c_apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             interrupt_i,
    input  logic             tx_ovf_i,
    input  logic             rx_unf_i,
    input  logic             clr_en_i,
    input  logic [INT_W-1:0] clr_mask_i,
    input  logic [INT_W-1:0] int_en_i,
    output logic [INT_W-1:0] int_stat_o,
    output logic             irq_o
);

    logic             int_dly_q, int_dly_d;
    logic [INT_W-1:0] int_stat_q, int_stat_d;
    logic             irq_q, irq_d;
    logic [INT_W-1:0] set_vec;

    always_comb begin
        int_dly_d           = interrupt_i;
        set_vec             = '0;
        set_vec[INT_CORE]   = interrupt_i & ~int_dly_q;
        set_vec[INT_TX_OVF] = tx_ovf_i;
        set_vec[INT_RX_UNF] = rx_unf_i;
        int_stat_d          = int_stat_q;
        if (clr_en_i) begin
            int_stat_d = int_stat_d & ~clr_mask_i;
        end
        int_stat_d = int_stat_d | set_vec;
        irq_d      = |(int_stat_q & int_en_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_dly_q  <= 1'b0;
            int_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            int_dly_q  <= int_dly_d;
            int_stat_q <= int_stat_d;
            irq_q      <= irq_d;
        end
    end

    assign int_stat_o = int_stat_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/i2c_apb_regs.sv
// APB3 slave register bank in front of i2c_top: configuration registers,
// TX push / RX pop strobes and a maskable interrupt line.
module i2c_apb_regs
    import i2c_apb_pkg::*;
#(
    parameter int          ADDR_W       = 5,
    parameter int          DATA_W       = 32,
    parameter logic [7:0]  PRESCALE_RST = 8'd8
) (
    input  logic              APB_clk_i,
    input  logic              APB_rst_ni,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    output logic [DATA_W-1:0] PRDATA_o,
    output logic              PREADY_o,
    output logic              PSLVERR_o,
    output logic [7:0]        prescale_o,
    output logic [7:0]        command_o,
    output logic [7:0]        slave_addr_rw_o,
    output logic [7:0]        data_transmit_o,
    output logic              tx_wr_en_o,
    input  logic [7:0]        data_receive_i,
    output logic              rx_rd_en_o,
    input  logic [7:0]        status_i,
    input  logic              interrupt_i,
    output logic              irq_o
);

    apb_state_e       state_q, state_d;
    logic [7:0]       prescale_q, prescale_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       slv_q, slv_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       int_en_q, int_en_d;
    logic             tx_wr_en_q, tx_wr_en_d;
    logic             rx_unf_q, rx_unf_d;

    reg_idx_e         reg_idx;
    logic             addr_ok, access, rx_rd, rd_err, wr_err;
    logic             wr_commit, tx_ovf, rx_unf_set, clr_en;
    logic [7:0]       rd_byte;
    logic [INT_W-1:0] int_stat;

    // Every word in the 5-bit space is mapped; only misalignment or high bits miss
    assign reg_idx = reg_idx_e'(PADDR_i[4:2]);
    assign addr_ok = (PADDR_i[1:0] == 2'b00) && ((PADDR_i >> 5) == '0);

    always_comb begin
        access     = (state_q == ST_ACCESS) && PSEL_i && PENABLE_i;
        rx_rd      = addr_ok && !PWRITE_i && (reg_idx == REG_RX_DATA);
        rd_byte    = '0;
        rd_err     = !addr_ok;
        if (addr_ok) begin
            case (reg_idx)
                REG_PRESCALE: rd_byte = prescale_q;
                REG_CMD:      rd_byte = cmd_q;
                REG_SLV_ADDR: rd_byte = slv_q;
                REG_TX_DATA:  rd_err  = 1'b1;
                REG_RX_DATA:  rd_byte = '0;
                REG_STATUS:   rd_byte = status_i;
                REG_INT_STAT: rd_byte = {{(8-INT_W){1'b0}}, int_stat};
                REG_INT_EN:   rd_byte = int_en_q;
                default:      rd_err  = 1'b1;
            endcase
        end
        wr_err = !addr_ok || (reg_idx == REG_RX_DATA) || (reg_idx == REG_STATUS) ||
                 ((reg_idx == REG_TX_DATA) && status_i[STAT_TX_FULL]);
        wr_commit  = access && PWRITE_i && !wr_err;
        tx_ovf     = access && PWRITE_i && addr_ok && (reg_idx == REG_TX_DATA) &&
                     status_i[STAT_TX_FULL];
        rx_unf_set = access && rx_rd && status_i[STAT_RX_EMPTY];
        rx_rd_en_o = access && rx_rd && !status_i[STAT_RX_EMPTY];
        clr_en     = wr_commit && (reg_idx == REG_INT_STAT);
    end

    always_comb begin
        state_d   = state_q;
        PREADY_o  = 1'b0;
        PSLVERR_o = 1'b0;
        PRDATA_o  = '0;
        case (state_q)
            ST_IDLE:  if (PSEL_i) state_d = ST_SETUP;
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (access && rx_rd) begin
                    state_d = ST_RX_WAIT;
                end else if (!rx_rd) begin
                    PREADY_o = 1'b1;
                    if (access) begin
                        PSLVERR_o = PWRITE_i ? wr_err : rd_err;
                        if (!PWRITE_i && !rd_err) PRDATA_o[7:0] = rd_byte;
                    end
                end
            end
            ST_RX_WAIT: begin
                state_d   = ST_IDLE;
                PREADY_o  = 1'b1;
                PSLVERR_o = rx_unf_q;
                if (!rx_unf_q) PRDATA_o[7:0] = data_receive_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prescale_d = prescale_q;
        cmd_d      = cmd_q;
        slv_d      = slv_q;
        tx_d       = tx_q;
        int_en_d   = int_en_q;
        tx_wr_en_d = 1'b0;
        rx_unf_d   = rx_unf_set;
        if (wr_commit) begin
            case (reg_idx)
                REG_PRESCALE: prescale_d = PWDATA_i[7:0];
                REG_CMD:      cmd_d      = PWDATA_i[7:0];
                REG_SLV_ADDR: slv_d      = PWDATA_i[7:0];
                REG_TX_DATA: begin
                    tx_d       = PWDATA_i[7:0];
                    tx_wr_en_d = 1'b1;
                end
                REG_INT_EN:   int_en_d   = PWDATA_i[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge APB_clk_i) begin
        if (!APB_rst_ni) begin
            state_q    <= ST_IDLE;
            prescale_q <= PRESCALE_RST;
            cmd_q      <= '0;
            slv_q      <= '0;
            tx_q       <= '0;
            int_en_q   <= '0;
            tx_wr_en_q <= 1'b0;
            rx_unf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            cmd_q      <= cmd_d;
            slv_q      <= slv_d;
            tx_q       <= tx_d;
            int_en_q   <= int_en_d;
            tx_wr_en_q <= tx_wr_en_d;
            rx_unf_q   <= rx_unf_d;
        end
    end

    i2c_irq_ctrl u_irq_ctrl (
        .clk         (APB_clk_i),
        .rst_n       (APB_rst_ni),
        .interrupt_i (interrupt_i),
        .tx_ovf_i    (tx_ovf),
        .rx_unf_i    (rx_unf_set),
        .clr_en_i    (clr_en),
        .clr_mask_i  (PWDATA_i[INT_W-1:0]),
        .int_en_i    (int_en_q[INT_W-1:0]),
        .int_stat_o  (int_stat),
        .irq_o       (irq_o)
    );

    assign prescale_o      = prescale_q;
    assign command_o       = cmd_q;
    assign slave_addr_rw_o = slv_q;
    assign data_transmit_o = tx_q;
    assign tx_wr_en_o      = tx_wr_en_q;

    // Upper data bits and reserved status bits are intentionally ignored
    logic unused_ok;
    assign unused_ok = ^{PWDATA_i[DATA_W-1:8], status_i};

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Bench for i2c_apb_regs: register-level model of the APB map plus a per-cycle
// compare of the configuration outputs and directed literal checks.
module tb_i2c_apb_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  prescale, command, slave_addr, data_tx;
    logic [7:0]  data_rx = 8'hA5;
    logic [7:0]  status = 8'h0A;
    logic        tx_wr_en, rx_rd_en, irq;
    logic        intr = 1'b0;

    always #5 clk = ~clk;

    i2c_apb_regs dut (
        .APB_clk_i       (clk),
        .APB_rst_ni      (rst_n),
        .PSEL_i          (psel),
        .PENABLE_i       (penable),
        .PWRITE_i        (pwrite),
        .PADDR_i         (paddr),
        .PWDATA_i        (pwdata),
        .PRDATA_o        (prdata),
        .PREADY_o        (pready),
        .PSLVERR_o       (pslverr),
        .prescale_o      (prescale),
        .command_o       (command),
        .slave_addr_rw_o (slave_addr),
        .data_transmit_o (data_tx),
        .tx_wr_en_o      (tx_wr_en),
        .data_receive_i  (data_rx),
        .rx_rd_en_o      (rx_rd_en),
        .status_i        (status),
        .interrupt_i     (intr),
        .irq_o           (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int tx_pulses = 0;
    int rx_pulses = 0;
    logic cmp_en = 1'b0;

    // Register-level model of what the bank should hold
    logic [7:0] m_prescale = 8'h08, m_cmd = 8'h00, m_slv = 8'h00, m_tx = 8'h00, m_int_en = 8'h00;
    logic [2:0] m_int_stat = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_prescale = 8'h08; m_cmd = 8'h00; m_slv = 8'h00; m_tx = 8'h00;
        m_int_en = 8'h00; m_int_stat = 3'b000;
    endtask

    always @(negedge clk) begin
        if (tx_wr_en) tx_pulses++;
        if (rx_rd_en) rx_pulses++;
        if (cmp_en) begin
            check("prescale_o", {24'h0, prescale}, {24'h0, m_prescale});
            check("command_o", {24'h0, command}, {24'h0, m_cmd});
            check("slave_addr_rw_o", {24'h0, slave_addr}, {24'h0, m_slv});
            check("data_transmit_o", {24'h0, data_tx}, {24'h0, m_tx});
        end
    end

    task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic pulse_int, output logic [31:0] rd, output logic err,
                            output int waits);
        logic got;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        got = 1'b0;
        while (!got && waits < 16) begin
            @(negedge clk);
            got = pready;
            if (!got) waits++;
        end
        if (!got) check("pready_timeout", 32'(got), 32'd1);
        rd  = prdata;
        err = pslverr;
        if (pulse_int) intr = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_access(input string name, input logic wr, input logic [4:0] addr,
                             input logic [31:0] wdata, input logic pulse_int,
                             output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err, err;
        int          exp_waits, waits;
        exp_rd    = 32'h0;
        exp_err   = 1'b0;
        exp_waits = (!wr && addr == 5'h10) ? 2 : 1;
        if (wr) begin
            exp_err = (addr[1:0] != 2'b00) || addr == 5'h10 || addr == 5'h14 ||
                      (addr == 5'h0C && status[0]);
        end else begin
            case (addr)
                5'h00: exp_rd = {24'h0, m_prescale};
                5'h04: exp_rd = {24'h0, m_cmd};
                5'h08: exp_rd = {24'h0, m_slv};
                5'h10: if (status[3]) exp_err = 1'b1; else exp_rd = {24'h0, data_rx};
                5'h14: exp_rd = {24'h0, status};
                5'h18: exp_rd = {29'h0, m_int_stat};
                5'h1C: exp_rd = {24'h0, m_int_en};
                default: exp_err = 1'b1;
            endcase
        end
        apb_xfer(wr, addr, wdata, pulse_int, rd, err, waits);
        check({name, "_pslverr"}, 32'(err), 32'(exp_err));
        check({name, "_waits"}, 32'(waits), 32'(exp_waits));
        if (!wr) check({name, "_prdata"}, rd, exp_rd);
        $display("xfer %s wr=%0b addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0b waits=%0d",
                 name, wr, addr, wdata[7:0], rd[7:0], err, waits);
        if (wr && !exp_err) begin
            case (addr)
                5'h00: m_prescale = wdata[7:0];
                5'h04: m_cmd      = wdata[7:0];
                5'h08: m_slv      = wdata[7:0];
                5'h0C: m_tx       = wdata[7:0];
                5'h18: m_int_stat = m_int_stat & ~wdata[2:0];
                5'h1C: m_int_en   = wdata[7:0];
                default: ;
            endcase
        end
        if (wr && addr == 5'h0C && status[0]) m_int_stat[1] = 1'b1;
        if (!wr && addr == 5'h10 && status[3]) m_int_stat[2] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int p0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        do_access("rd_prescale", 1'b0, 5'h00, 32'h0, 1'b0, rd);
        check("lit_prescale", rd, 32'h08);
        do_access("rd_cmd", 1'b0, 5'h04, 32'h0, 1'b0, rd);
        check("lit_cmd", rd, 32'h00);

        // Configuration writes
        do_access("wr_cmd", 1'b1, 5'h04, 32'hC0, 1'b0, rd);
        check("lit_command_o", {24'h0, command}, 32'hC0);
        do_access("wr_slv", 1'b1, 5'h08, 32'hFFFF_FFCE, 1'b0, rd);
        check("lit_slave_addr", {24'h0, slave_addr}, 32'hCE);
        do_access("rd_slv", 1'b0, 5'h08, 32'h0, 1'b0, rd);
        do_access("wr_prescale", 1'b1, 5'h00, 32'h20, 1'b0, rd);

        // TX push, then overflow
        p0 = tx_pulses;
        do_access("wr_tx", 1'b1, 5'h0C, 32'h31, 1'b0, rd);
        idle(2);
        check("lit_tx_pulse", 32'(tx_pulses - p0), 32'd1);
        check("lit_data_tx", {24'h0, data_tx}, 32'h31);
        status = 8'h0B;
        p0 = tx_pulses;
        do_access("wr_tx_full", 1'b1, 5'h0C, 32'h55, 1'b0, rd);
        idle(2);
        check("lit_tx_full_nopulse", 32'(tx_pulses - p0), 32'd0);
        status = 8'h0A;
        do_access("rd_int_stat_ovf", 1'b0, 5'h18, 32'h0, 1'b0, rd);
        check("lit_int_stat_ovf", rd, 32'h02);

        // RX pop, then underflow
        status = 8'h02;
        p0 = rx_pulses;
        do_access("rd_rx", 1'b0, 5'h10, 32'h0, 1'b0, rd);
        check("lit_rx_data", rd, 32'hA5);
        check("lit_rx_pulse", 32'(rx_pulses - p0), 32'd1);
        status = 8'h0A;
        p0 = rx_pulses;
        do_access("rd_rx_empty", 1'b0, 5'h10, 32'h0, 1'b0, rd);
        check("lit_rx_empty_data", rd, 32'h0);
        check("lit_rx_empty_nopulse", 32'(rx_pulses - p0), 32'd0);
        do_access("rd_int_stat_unf", 1'b0, 5'h18, 32'h0, 1'b0, rd);
        check("lit_int_stat_unf", rd, 32'h06);

        // Access errors
        do_access("wr_status_ro", 1'b1, 5'h14, 32'hFF, 1'b0, rd);
        do_access("rd_tx_wo", 1'b0, 5'h0C, 32'h0, 1'b0, rd);
        do_access("rd_unaligned", 1'b0, 5'h01, 32'h0, 1'b0, rd);
        do_access("wr_unaligned", 1'b1, 5'h06, 32'h11, 1'b0, rd);
        do_access("rd_status", 1'b0, 5'h14, 32'h0, 1'b0, rd);

        // Interrupt path
        do_access("wr_int_en", 1'b1, 5'h1C, 32'h01, 1'b0, rd);
        do_access("rd_int_en", 1'b0, 5'h1C, 32'h0, 1'b0, rd);
        idle(2);
        @(negedge clk);
        check("lit_irq_masked", 32'(irq), 32'd0);
        @(posedge clk); #1 intr = 1'b1;
        @(posedge clk); #1 intr = 1'b0;
        m_int_stat[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("lit_irq_set", 32'(irq), 32'd1);
        do_access("clr_with_edge", 1'b1, 5'h18, 32'h01, 1'b1, rd);
        intr = 1'b0;
        m_int_stat[0] = 1'b1;
        idle(2);
        @(negedge clk);
        check("lit_irq_held", 32'(irq), 32'd1);
        do_access("rd_int_stat_held", 1'b0, 5'h18, 32'h0, 1'b0, rd);
        check("lit_int_stat_held", rd, 32'h07);
        do_access("clr_all", 1'b1, 5'h18, 32'h07, 1'b0, rd);
        idle(2);
        @(negedge clk);
        check("lit_irq_cleared", 32'(irq), 32'd0);
        do_access("rd_int_stat_clr", 1'b0, 5'h18, 32'h0, 1'b0, rd);

        // Reset during the ACCESS cycle of a TX write
        p0 = tx_pulses;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h0C; pwdata = 32'h77;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("lit_rst_in_access", 32'(pready), 32'd1);
        @(posedge clk); #1;
        model_reset();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("lit_rst_pready", 32'(pready), 32'd0);
        check("lit_rst_irq", 32'(irq), 32'd0);
        check("lit_rst_prescale", {24'h0, prescale}, 32'h08);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);
        check("lit_rst_no_pulse", 32'(tx_pulses - p0), 32'd0);
        check("lit_rst_data_tx", {24'h0, data_tx}, 32'h0);
        check("lit_rst_command", {24'h0, command}, 32'h0);
        do_access("rd_prescale_rst", 1'b0, 5'h00, 32'h0, 1'b0, rd);
        check("lit_prescale_rst", rd, 32'h08);
        do_access("rd_int_en_rst", 1'b0, 5'h1C, 32'h0, 1'b0, rd);
        do_access("rd_int_stat_rst", 1'b0, 5'h18, 32'h0, 1'b0, rd);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
